collision_detector: RTL and testbench

//  Upstream of the ball FSM. Compares ball position/size against the walls and both paddles once per

---
 rtl/pong_pkg.sv | 28 ++
 rtl/span_overlap.sv | 15 +
 rtl/collision_detector.sv | 206 ++++++++++++++++++++
 tb/tb_collision_detector.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the pong datapath: bounce commands, collision FSM states,
// default playfield size and the per-tick hit summary.
package pong_pkg;

   localparam int SCREEN_X_DEF = 100;
   localparam int SCREEN_Y_DEF = 100;

   typedef enum logic [1:0] {
      BOUNCE_NONE   = 2'b00,
      BOUNCE_PADDLE = 2'b01,
      BOUNCE_WALL   = 2'b10
   } bounce_t;

   typedef enum logic [1:0] {
      PLAY = 2'b00,
      GOAL = 2'b01,
      OVER = 2'b10
   } state_t;

   typedef struct packed {
      logic wall;
      logic pad_l;
      logic pad_r;
      logic miss_l;
      logic miss_r;
   } hits_t;

endpackage

// File: rtl/span_overlap.sv
// Half-open interval overlap test: [a_lo, a_hi) intersects [b_lo, b_hi).
// Strict compares mean spans that only touch at an edge do not overlap.
module span_overlap #(
   parameter int W = 9
) (
   input  logic [W-1:0] a_lo,
   input  logic [W-1:0] a_hi,
   input  logic [W-1:0] b_lo,
   input  logic [W-1:0] b_hi,
   output logic         overlap
);

   assign overlap = (a_hi > b_lo) && (a_lo < b_hi);

endmodule

// File: rtl/collision_detector.sv
// Per-tick ball collision evaluation: bounce commands, goal detection, scoring,
// re-serve after a goal hold and game-over latch.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   PLAY  | ball in flight; misses score, paddle/wall hits emit bounces
//   GOAL  | frozen after a goal; hold counter runs, then ball re-serve
//   OVER  | a player reached the winning score; only reset leaves
module collision_detector
   import pong_pkg::*;
#(
   parameter int SCREEN_X   = SCREEN_X_DEF,
   parameter int SCREEN_Y   = SCREEN_Y_DEF,
   parameter int COORD_W    = 8,
   parameter int PADDLE_W   = 2,
   parameter int PADDLE_H   = 20,
   parameter int PADDLE_L_X = 2,
   parameter int PADDLE_R_X = 96,
   parameter int COOLDOWN   = 3,
   parameter int GOAL_HOLD  = 60,
   parameter int SCORE_W    = 4,
   parameter int WIN_SCORE  = 9
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               tick,
   input  logic [COORD_W-1:0] ball_x,
   input  logic [COORD_W-1:0] ball_y,
   input  logic [COORD_W-1:0] ball_w,
   input  logic [COORD_W-1:0] ball_h,
   input  logic [COORD_W-1:0] paddle_l_y,
   input  logic [COORD_W-1:0] paddle_r_y,
   output logic [1:0]         bounce,
   output logic               goal_l,
   output logic               goal_r,
   output logic               ball_reset,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               game_over
);

   localparam int XW = COORD_W + 1;
   localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int HW = (GOAL_HOLD > 1) ? $clog2(GOAL_HOLD + 1) : 1;

   localparam logic [XW-1:0]      PL_LO    = XW'(PADDLE_L_X);
   localparam logic [XW-1:0]      PL_HI    = XW'(PADDLE_L_X + PADDLE_W);
   localparam logic [XW-1:0]      PR_LO    = XW'(PADDLE_R_X);
   localparam logic [XW-1:0]      PR_HI    = XW'(PADDLE_R_X + PADDLE_W);
   localparam logic [XW-1:0]      SX_V     = XW'(SCREEN_X);
   localparam logic [XW-1:0]      SY_V     = XW'(SCREEN_Y);
   localparam logic [XW-1:0]      PH_V     = XW'(PADDLE_H);
   localparam logic [CW-1:0]      COOL_V   = CW'(COOLDOWN);
   localparam logic [HW-1:0]      HOLD_V   = HW'(GOAL_HOLD - 1);
   localparam logic [SCORE_W-1:0] WIN_V    = SCORE_W'(WIN_SCORE);

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= WIN_V) ? WIN_V : s + 1'b1;
   endfunction

   // Edge sums carry one extra bit so large positions/sizes never wrap.
   logic [XW-1:0] bx_lo, bx_hi, by_lo, by_hi;
   logic [XW-1:0] pl_lo, pl_hi, pr_lo, pr_hi;

   assign bx_lo = XW'(ball_x);
   assign bx_hi = XW'(ball_x) + XW'(ball_w);
   assign by_lo = XW'(ball_y);
   assign by_hi = XW'(ball_y) + XW'(ball_h);
   assign pl_lo = XW'(paddle_l_y);
   assign pl_hi = XW'(paddle_l_y) + PH_V;
   assign pr_lo = XW'(paddle_r_y);
   assign pr_hi = XW'(paddle_r_y) + PH_V;

   logic ovl_lx, ovl_ly, ovl_rx, ovl_ry;

   span_overlap #(.W(XW)) u_ovl_lx (
      .a_lo(bx_lo), .a_hi(bx_hi), .b_lo(PL_LO), .b_hi(PL_HI), .overlap(ovl_lx)
   );
   span_overlap #(.W(XW)) u_ovl_ly (
      .a_lo(by_lo), .a_hi(by_hi), .b_lo(pl_lo), .b_hi(pl_hi), .overlap(ovl_ly)
   );
   span_overlap #(.W(XW)) u_ovl_rx (
      .a_lo(bx_lo), .a_hi(bx_hi), .b_lo(PR_LO), .b_hi(PR_HI), .overlap(ovl_rx)
   );
   span_overlap #(.W(XW)) u_ovl_ry (
      .a_lo(by_lo), .a_hi(by_hi), .b_lo(pr_lo), .b_hi(pr_hi), .overlap(ovl_ry)
   );

   hits_t hits;

   always_comb begin
      hits        = '0;
      hits.wall   = (ball_y == '0) || (by_hi >= SY_V);
      hits.pad_l  = ovl_lx && ovl_ly;
      hits.pad_r  = ovl_rx && ovl_ry;
      hits.miss_l = (ball_x == '0) && !hits.pad_l;
      hits.miss_r = (bx_hi >= SX_V) && !hits.pad_r;
   end

   state_t             state_q, state_d;
   logic [CW-1:0]      x_cool_q, x_cool_d;
   logic [CW-1:0]      y_cool_q, y_cool_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [SCORE_W-1:0] score_l_q, score_l_d;
   logic [SCORE_W-1:0] score_r_q, score_r_d;
   bounce_t            bounce_q, bounce_d;
   logic               goal_l_q, goal_l_d;
   logic               goal_r_q, goal_r_d;
   logic               ball_reset_q, ball_reset_d;
   logic               game_over_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= PLAY;
         x_cool_q     <= '0;
         y_cool_q     <= '0;
         hold_q       <= '0;
         score_l_q    <= '0;
         score_r_q    <= '0;
         bounce_q     <= BOUNCE_NONE;
         goal_l_q     <= 1'b0;
         goal_r_q     <= 1'b0;
         ball_reset_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_cool_q     <= x_cool_d;
         y_cool_q     <= y_cool_d;
         hold_q       <= hold_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         bounce_q     <= bounce_d;
         goal_l_q     <= goal_l_d;
         goal_r_q     <= goal_r_d;
         ball_reset_q <= ball_reset_d;
         game_over_q  <= (state_d == OVER);
      end
   end

   always_comb begin
      state_d      = state_q;
      x_cool_d     = x_cool_q;
      y_cool_d     = y_cool_q;
      hold_d       = hold_q;
      score_l_d    = score_l_q;
      score_r_d    = score_r_q;
      bounce_d     = BOUNCE_NONE;
      goal_l_d     = 1'b0;
      goal_r_d     = 1'b0;
      ball_reset_d = 1'b0;

      if (tick) begin
         unique case (state_q)
            PLAY: begin
               if (x_cool_q != '0) x_cool_d = x_cool_q - 1'b1;
               if (y_cool_q != '0) y_cool_d = y_cool_q - 1'b1;

               // Masked axes fall through so a simultaneous wall hit is emitted
               // on the first tick the paddle axis is in cooldown.
               if (hits.miss_l) begin
                  score_r_d = sat_inc(score_r_q);
                  goal_r_d  = 1'b1;
                  hold_d    = HOLD_V;
                  state_d   = (score_r_d == WIN_V) ? OVER : GOAL;
               end else if (hits.miss_r) begin
                  score_l_d = sat_inc(score_l_q);
                  goal_l_d  = 1'b1;
                  hold_d    = HOLD_V;
                  state_d   = (score_l_d == WIN_V) ? OVER : GOAL;
               end else if ((hits.pad_l || hits.pad_r) && (x_cool_q == '0)) begin
                  bounce_d = BOUNCE_PADDLE;
                  x_cool_d = COOL_V;
               end else if (hits.wall && (y_cool_q == '0)) begin
                  bounce_d = BOUNCE_WALL;
                  y_cool_d = COOL_V;
               end
            end
            GOAL: begin
               if (hold_q == '0) begin
                  ball_reset_d = 1'b1;
                  x_cool_d     = '0;
                  y_cool_d     = '0;
                  state_d      = PLAY;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
            OVER: begin
               state_d = OVER;
            end
            default: begin
               state_d = PLAY;
            end
         endcase
      end
   end

   assign bounce     = bounce_q;
   assign goal_l     = goal_l_q;
   assign goal_r     = goal_r_q;
   assign ball_reset = ball_reset_q;
   assign score_l    = score_l_q;
   assign score_r    = score_r_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: a rule-level reference model predicts
// every registered response; a monitor compares the DUT the cycle after each tick/reset.
module tb_collision_detector;

   localparam int SX  = 100;
   localparam int SY  = 100;
   localparam int PW  = 2;
   localparam int PH  = 20;
   localparam int PLX = 2;
   localparam int PRX = 96;
   localparam int CD  = 3;
   localparam int GH  = 60;
   localparam int WIN = 9;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick  = 1'b0;
   logic [7:0] ball_x = 8'd50, ball_y = 8'd40, ball_w = 8'd5, ball_h = 8'd5;
   logic [7:0] paddle_l_y = 8'd80, paddle_r_y = 8'd80;
   logic [1:0] bounce;
   logic       goal_l, goal_r, ball_reset, game_over;
   logic [3:0] score_l, score_r;

   collision_detector dut (
      .clock(clock), .reset(reset), .tick(tick),
      .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w), .ball_h(ball_h),
      .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
      .bounce(bounce), .goal_l(goal_l), .goal_r(goal_r), .ball_reset(ball_reset),
      .score_l(score_l), .score_r(score_r), .game_over(game_over)
   );

   always #5 clock = ~clock;

   typedef struct {
      int bounce;
      int gl;
      int gr;
      int br;
      int sl;
      int sr;
      int go;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   int   tests  = 0;
   int   failed = 0;
   bit   armed  = 1'b0;

   // Reference game state: mode 0 = playing, 1 = goal freeze, 2 = game over.
   int m_mode = 0, m_xc = 0, m_yc = 0, m_gt = 0, m_sl = 0, m_sr = 0;

   task automatic model_step(input bit r, input bit t, output exp_t e);
      int bx, by, bw, bh, pl, pr, xc0, yc0;
      bit hl, hr, ml, mr, wall;
      e = '{default: 0};
      if (r) begin
         m_mode = 0; m_xc = 0; m_yc = 0; m_gt = 0; m_sl = 0; m_sr = 0;
      end else if (t) begin
         bx = int'(ball_x); by = int'(ball_y); bw = int'(ball_w); bh = int'(ball_h);
         pl = int'(paddle_l_y); pr = int'(paddle_r_y);
         hl   = (bx <= PLX + PW - 1) && (bx + bw > PLX) && (by + bh > pl) && (by < pl + PH);
         hr   = (bx + bw > PRX) && (bx <= PRX + PW - 1) && (by + bh > pr) && (by < pr + PH);
         ml   = (bx == 0) && !hl;
         mr   = (bx + bw >= SX) && !hr;
         wall = (by == 0) || (by + bh >= SY);
         if (m_mode == 0) begin
            xc0 = m_xc; yc0 = m_yc;
            if (m_xc > 0) m_xc--;
            if (m_yc > 0) m_yc--;
            if (ml) begin
               if (m_sr < WIN) m_sr++;
               e.gr = 1; m_gt = 0;
               m_mode = (m_sr == WIN) ? 2 : 1;
            end else if (mr) begin
               if (m_sl < WIN) m_sl++;
               e.gl = 1; m_gt = 0;
               m_mode = (m_sl == WIN) ? 2 : 1;
            end else if ((hl || hr) && xc0 == 0) begin
               e.bounce = 1; m_xc = CD;
            end else if (wall && yc0 == 0) begin
               e.bounce = 2; m_yc = CD;
            end
         end else if (m_mode == 1) begin
            m_gt++;
            if (m_gt == GH) begin
               e.br = 1; m_xc = 0; m_yc = 0; m_mode = 0;
            end
         end
      end
      e.sl = m_sl; e.sr = m_sr; e.go = (m_mode == 2) ? 1 : 0;
   endtask

   // Monitor: responses appear the edge after a tick/reset cycle; otherwise pulses idle.
   initial begin
      exp_t e;
      bit r_s, t_s, ok;
      logic [15:0] act, expv;
      last_exp = '{default: 0};
      forever begin
         @(posedge clock);
         r_s = reset; t_s = tick;
         #2;
         if (armed) begin
            ok = 1'b1;
            if (r_s || t_s) begin
               if (sb.size() == 0) begin
                  ok = 1'b0;
                  tests++; failed++;
                  $display("FAIL scoreboard_empty at %0t: response with no prediction", $time);
               end else begin
                  e = sb.pop_front();
                  last_exp = e;
               end
            end else begin
               e = last_exp;
               e.bounce = 0; e.gl = 0; e.gr = 0; e.br = 0;
            end
            if (ok) begin
               act  = {bounce, goal_l, goal_r, ball_reset, game_over, score_l, score_r, 2'b00};
               expv = {2'(e.bounce), 1'(e.gl), 1'(e.gr), 1'(e.br), 1'(e.go),
                       4'(e.sl), 4'(e.sr), 2'b00};
               tests++;
               if (act !== expv) begin
                  failed++;
                  $display("FAIL sb_compare at %0t: got b=%0d gl=%0b gr=%0b br=%0b go=%0b sl=%0d sr=%0d, expected b=%0d gl=%0d gr=%0d br=%0d go=%0d sl=%0d sr=%0d",
                           $time, bounce, goal_l, goal_r, ball_reset, game_over, score_l, score_r,
                           e.bounce, e.gl, e.gr, e.br, e.go, e.sl, e.sr);
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached (%0d tests, %0d failed)", tests, failed);
      $fatal(1, "watchdog");
   end

   task automatic cyc(input bit t, input bit r);
      exp_t e;
      @(negedge clock);
      tick = t; reset = r;
      if (r || t) begin
         model_step(r, t, e);
         sb.push_back(e);
      end
      armed = 1'b1;
      @(posedge clock);
      #3;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input int expv);
      tests++;
      if (act !== 8'(expv)) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic set_ball(input int x, input int y, input int w, input int h,
                           input int pl, input int pr);
      ball_x = 8'(x); ball_y = 8'(y); ball_w = 8'(w); ball_h = 8'(h);
      paddle_l_y = 8'(pl); paddle_r_y = 8'(pr);
   endtask

   function automatic int rand_pos(input int hi_lo);
      case ($urandom_range(0, 4))
         0:       return 0;
         1:       return $urandom_range(0, 6);
         2:       return $urandom_range(hi_lo, 99);
         3:       return $urandom_range(0, 255);
         default: return $urandom_range(0, 99);
      endcase
   endfunction

   initial begin
      int bad;
      bit br_seen;

      cyc(0, 1);
      chk("reset_flags", {3'b000, bounce, goal_l, goal_r, ball_reset}, 0);
      chk("reset_scores", {score_l, score_r}, 0);
      chk("reset_game_over", {7'd0, game_over}, 0);

      // Wall hit then y-axis cooldown
      set_ball(50, 0, 5, 5, 80, 80);
      cyc(1, 0); chk("t1_wall", {6'd0, bounce}, 2);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0); cyc(1, 0); chk("t1_cooldown", {6'd0, bounce}, 0);
      end
      cyc(0, 0); cyc(1, 0); chk("t1_cool_expired", {6'd0, bounce}, 2);

      // Paddle hit, paddle miss, goal
      set_ball(3, 40, 5, 5, 35, 80);
      cyc(1, 0); chk("t2_paddle", {6'd0, bounce}, 1);
      paddle_l_y = 8'd60;
      cyc(1, 0); chk("t2_no_overlap", {6'd0, bounce}, 0);
      ball_x = 8'd0;
      cyc(1, 0); chk("t2_goal_r", {7'd0, goal_r}, 1); chk("t2_score_r", {4'd0, score_r}, 1);
      cyc(0, 0); chk("t2_goal_pulse_len", {7'd0, goal_r}, 0);

      // Goal hold, re-serve, then play resumes
      set_ball(50, 0, 5, 5, 80, 80);
      bad = 0;
      for (int k = 0; k < GH - 1; k++) begin
         cyc(1, 0);
         if (bounce !== 2'b00 || ball_reset !== 1'b0) bad++;
      end
      chk("t4_hold_quiet", 8'(bad), 0);
      cyc(1, 0); chk("t4_ball_reset", {7'd0, ball_reset}, 1);
      cyc(0, 0); chk("t4_reset_pulse_len", {7'd0, ball_reset}, 0);
      cyc(1, 0); chk("t4_wall_after_serve", {6'd0, bounce}, 2);

      // Corner: paddle first, wall on the next tick
      cyc(0, 1);
      set_ball(3, 0, 5, 5, 0, 80);
      cyc(1, 0); chk("t3_corner_paddle", {6'd0, bounce}, 1);
      cyc(1, 0); chk("t3_corner_wall", {6'd0, bounce}, 2);

      // Run left player to the winning score
      cyc(0, 1);
      for (int g = 0; g < WIN - 1; g++) begin
         set_ball(96, 40, 5, 5, 80, 80);
         cyc(1, 0);
         set_ball(50, 40, 5, 5, 80, 80);
         repeat (GH) cyc(1, 0);
      end
      chk("t5_score_8", {4'd0, score_l}, WIN - 1);
      set_ball(96, 40, 5, 5, 80, 80);
      cyc(1, 0);
      chk("t5_goal_l", {7'd0, goal_l}, 1);
      chk("t5_score_win", {4'd0, score_l}, WIN);
      chk("t5_game_over", {7'd0, game_over}, 1);
      set_ball(0, 40, 5, 5, 80, 80);
      repeat (5) cyc(1, 0);
      chk("t5_over_no_goal", {7'd0, goal_r}, 0);
      chk("t5_over_score_r", {4'd0, score_r}, 0);
      set_ball(50, 40, 5, 5, 80, 80);
      repeat (GH + 5) cyc(1, 0);
      chk("t5_still_over", {7'd0, game_over}, 1);
      cyc(0, 1);
      chk("t5_reset_flags", {3'b000, bounce, goal_l, goal_r, ball_reset}, 0);
      chk("t5_reset_scores", {score_l, score_r}, 0);
      chk("t5_reset_over", {7'd0, game_over}, 0);

      // Reset in the middle of a goal hold
      set_ball(0, 40, 5, 5, 80, 80);
      cyc(1, 0); chk("t6_goal_r", {7'd0, goal_r}, 1);
      set_ball(50, 40, 5, 5, 80, 80);
      repeat (10) cyc(1, 0);
      cyc(0, 1);
      chk("t6_reset_scores", {score_l, score_r}, 0);
      br_seen = 1'b0;
      repeat (GH + 10) begin
         cyc(1, 0);
         if (ball_reset !== 1'b0) br_seen = 1'b1;
      end
      chk("t6_no_reserve", {7'd0, br_seen}, 0);
      set_ball(50, 0, 5, 5, 80, 80);
      cyc(1, 0); chk("t6_play_wall", {6'd0, bounce}, 2);

      // Randomized play
      for (int n = 0; n < 4000; n++) begin
         set_ball(rand_pos(90), rand_pos(92), $urandom_range(1, 8), $urandom_range(1, 8),
                  $urandom_range(0, 90), $urandom_range(0, 90));
         if ($urandom_range(0, 15) == 0) begin
            ball_w = 8'($urandom_range(0, 255));
            ball_h = 8'($urandom_range(0, 255));
         end
         cyc($urandom_range(0, 2) != 0, $urandom_range(0, 249) == 0);
      end

      cyc(0, 0);
      cyc(0, 0);
      if (sb.size() != 0) begin
         tests++; failed++;
         $display("FAIL sb_leftover: %0d predictions never matched, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
